// File: rtl/ddr3_dp_pkg.sv
// Shared types for the DDR3 DQ burst data path: FSM states, burst length, beat index.
package ddr3_dp_pkg;

   localparam int BL = 8;

   typedef logic [2:0] beat_idx_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_WAIT  = 3'd1,
      WR_PRE   = 3'd2,
      WR_BURST = 3'd3,
      WR_POST  = 3'd4,
      RD_WAIT  = 3'd5,
      RD_CAP   = 3'd6,
      TURN     = 3'd7
   } dp_state_e;

   // Cycles spent in the *_WAIT state; a latency of 0 behaves like 1.
   function automatic logic [3:0] wait_cycles(input logic [3:0] lat);
      return (lat == 4'd0) ? 4'd0 : lat - 4'd1;
   endfunction

endpackage

// File: rtl/ddr3_rd_capture.sv
// Assembles BL read beats into one burst word; done pulses the cycle after the last beat.
module ddr3_rd_capture
   import ddr3_dp_pkg::*;
#(
   parameter int DQ_BITS = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    last,
   input  logic [DQ_BITS-1:0]      din,
   output logic [DQ_BITS*BL-1:0]   data,
   output logic                    done
);

   localparam int SH_W = DQ_BITS*(BL-1);

   // Holds beats 0..BL-2 with beat0 at the bottom; the final beat goes straight into data.
   logic [SH_W-1:0] shreg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         data  <= '0;
         done  <= 1'b0;
      end else begin
         done <= en & last;
         if (en) begin
            shreg <= {din, shreg[SH_W-1:DQ_BITS]};
            if (last) data <= {din, shreg};
         end
      end
   end

endmodule

// File: rtl/ddr3_dq_burst_ctrl.sv
// DQ/DM/DQS write-beat sequencer and read-burst capture feeding the DDR3 pad stage.
module ddr3_dq_burst_ctrl
   import ddr3_dp_pkg::*;
#(
   parameter int DQ_BITS  = 16,
   parameter int DM_BITS  = 2,
   parameter int DQS_BITS = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    cmd_ready,
   input  logic                    wr_valid,
   input  logic [DQ_BITS*BL-1:0]   wr_data,
   input  logic [DM_BITS*BL-1:0]   wr_mask,
   input  logic                    rd_valid,
   input  logic [3:0]              cwl,
   input  logic [3:0]              cl,
   output logic                    rd_data_valid,
   output logic [DQ_BITS*BL-1:0]   rd_data,
   output logic                    ddr3_rw,
   output logic                    ddr3_odt,
   output logic [DQ_BITS-1:0]      ddr3_data_out,
   output logic [DQ_BITS*BL-1:0]   ddr3_data_all_out,
   output logic [DM_BITS-1:0]      ddr3_dm_tdqs_out,
   output logic [DQS_BITS-1:0]     ddr3_dqs_out,
   output logic [DQS_BITS-1:0]     ddr3_dqs_n_out,
   input  logic [DQ_BITS-1:0]      ddr3_data_in
);

   dp_state_e             state, state_d;
   logic [3:0]            lat_cnt, lat_d;
   beat_idx_t             beat_cnt, beat_d;
   logic                  wr_acc;
   logic                  wr_win_d;
   logic [DQ_BITS*BL-1:0] wr_buf;
   logic [DM_BITS*BL-1:0] wr_mask_q;

   always_comb begin
      state_d = state;
      lat_d   = lat_cnt;
      wr_acc  = 1'b0;
      case (state)
         IDLE: begin
            // A simultaneous read is simply not accepted; the scheduler re-presents it.
            if (wr_valid) begin
               wr_acc  = 1'b1;
               lat_d   = wait_cycles(cwl);
               state_d = (lat_d == 4'd0) ? WR_PRE : WR_WAIT;
            end else if (rd_valid) begin
               lat_d   = wait_cycles(cl);
               state_d = (lat_d == 4'd0) ? RD_CAP : RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (lat_cnt <= 4'd1) state_d = WR_PRE;
            if (lat_cnt != 4'd0) lat_d = lat_cnt - 4'd1;
         end
         WR_PRE:   state_d = WR_BURST;
         WR_BURST: if (beat_cnt == 3'd7) state_d = WR_POST;
         WR_POST:  state_d = TURN;
         RD_WAIT: begin
            if (lat_cnt <= 4'd1) state_d = RD_CAP;
            if (lat_cnt != 4'd0) lat_d = lat_cnt - 4'd1;
         end
         RD_CAP:   if (beat_cnt == 3'd7) state_d = TURN;
         TURN:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Beat index advances only while beats are on the bus, so it wraps to 0 exactly at burst end.
   assign beat_d   = (state == WR_BURST || state == RD_CAP) ? beat_cnt + 3'd1 : beat_cnt;
   assign wr_win_d = (state_d == WR_PRE) || (state_d == WR_BURST) || (state_d == WR_POST);

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         lat_cnt          <= '0;
         beat_cnt         <= '0;
         cmd_ready        <= 1'b1;
         ddr3_rw          <= 1'b1;
         ddr3_odt         <= 1'b0;
         ddr3_dqs_out     <= '0;
         ddr3_dqs_n_out   <= '1;
         ddr3_data_out    <= '0;
         ddr3_dm_tdqs_out <= '0;
         wr_buf           <= '0;
         wr_mask_q        <= '0;
      end else begin
         state     <= state_d;
         lat_cnt   <= lat_d;
         beat_cnt  <= beat_d;
         cmd_ready <= (state_d == IDLE);
         ddr3_rw   <= ~wr_win_d;
         ddr3_odt  <= wr_win_d;
         if (wr_acc) begin
            wr_buf    <= wr_data;
            wr_mask_q <= wr_mask;
         end
         if (state_d == WR_BURST) begin
            ddr3_dqs_out     <= {DQS_BITS{~beat_d[0]}};
            ddr3_dqs_n_out   <= {DQS_BITS{beat_d[0]}};
            ddr3_data_out    <= wr_buf[int'(beat_d)*DQ_BITS +: DQ_BITS];
            ddr3_dm_tdqs_out <= wr_mask_q[int'(beat_d)*DM_BITS +: DM_BITS];
         end else begin
            ddr3_dqs_out     <= '0;
            ddr3_dqs_n_out   <= '1;
         end
      end
   end

   assign ddr3_data_all_out = wr_buf;

   ddr3_rd_capture #(
      .DQ_BITS (DQ_BITS)
   ) u_rd_capture (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == RD_CAP),
      .last  (beat_cnt == 3'd7),
      .din   (ddr3_data_in),
      .data  (rd_data),
      .done  (rd_data_valid)
   );

endmodule

// File: tb/tb_ddr3_dq_burst_ctrl.sv
// Directed bench: write/read timing, collision, zero latency, mid-burst reset, write->read turnaround.
module tb_ddr3_dq_burst_ctrl;

   logic         clk, rst_n;
   logic         cmd_ready, wr_valid, rd_valid, rd_data_valid;
   logic [127:0] wr_data, rd_data, ddr3_data_all_out;
   logic [15:0]  wr_mask;
   logic [3:0]   cwl, cl;
   logic         ddr3_rw, ddr3_odt;
   logic [15:0]  ddr3_data_out, ddr3_data_in;
   logic [1:0]   ddr3_dm_tdqs_out, ddr3_dqs_out, ddr3_dqs_n_out;

   int n_checks = 0;
   int n_fail   = 0;

   ddr3_dq_burst_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_mask(wr_mask),
      .rd_valid(rd_valid), .cwl(cwl), .cl(cl),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .ddr3_rw(ddr3_rw), .ddr3_odt(ddr3_odt),
      .ddr3_data_out(ddr3_data_out), .ddr3_data_all_out(ddr3_data_all_out),
      .ddr3_dm_tdqs_out(ddr3_dm_tdqs_out), .ddr3_dqs_out(ddr3_dqs_out),
      .ddr3_dqs_n_out(ddr3_dqs_n_out), .ddr3_data_in(ddr3_data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Called at a negedge with cmd_ready high; returns at the negedge of cycle T+1.
   task automatic issue(input logic w, input logic r, input logic [3:0] wl, input logic [3:0] rl,
                        input logic [127:0] d, input logic [15:0] m);
      wr_valid = w; rd_valid = r; cwl = wl; cl = rl; wr_data = d; wr_mask = m;
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;
      cwl = 4'd15; cl = 4'd15; wr_data = {8{16'hBEEF}}; wr_mask = 16'hFFFF;
   endtask

   function automatic logic [127:0] pattern(input logic [15:0] base);
      logic [127:0] v;
      for (int i = 0; i < 8; i++) v[i*16 +: 16] = base + 16'(i);
      return v;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; cwl = 4'd0; cl = 4'd0;
      wr_data = '0; wr_mask = '0; ddr3_data_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cmd_ready, ddr3_rw, ddr3_odt, rd_data_valid} !== 4'b1100) begin
         n_fail++; $display("FAIL reset_ctrl got %b exp 1100", {cmd_ready, ddr3_rw, ddr3_odt, rd_data_valid});
      end
      n_checks++;
      if ({ddr3_dqs_out, ddr3_dqs_n_out, ddr3_dm_tdqs_out} !== 6'b00_11_00 || ddr3_data_out !== 16'h0
          || rd_data !== '0 || ddr3_data_all_out !== '0) begin
         n_fail++; $display("FAIL reset_data dqs=%b dqs_n=%b dm=%b dout=%h", ddr3_dqs_out, ddr3_dqs_n_out,
                            ddr3_dm_tdqs_out, ddr3_data_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write;
      logic [127:0] d;
      logic exp_rw;
      logic [1:0] exp_dqs;
      d = pattern(16'h1000);
      issue(1'b1, 1'b0, 4'd5, 4'd0, d, 16'h0000);
      for (int k = 1; k <= 16; k++) begin
         exp_rw  = !(k >= 5 && k <= 14);
         exp_dqs = (k >= 6 && k <= 13 && ((k - 6) % 2 == 0)) ? 2'b11 : 2'b00;
         n_checks++;
         if (ddr3_rw !== exp_rw || ddr3_odt !== !exp_rw) begin
            n_fail++; $display("FAIL wr_rw_odt k=%0d got rw=%b odt=%b exp rw=%b", k, ddr3_rw, ddr3_odt, exp_rw);
         end
         n_checks++;
         if (ddr3_dqs_out !== exp_dqs || ddr3_dqs_n_out !== ~exp_dqs) begin
            n_fail++; $display("FAIL wr_dqs k=%0d got %b/%b exp %b", k, ddr3_dqs_out, ddr3_dqs_n_out, exp_dqs);
         end
         if (k >= 6) begin
            n_checks++;
            if (ddr3_data_out !== 16'h1000 + 16'((k > 13) ? 7 : k - 6) || ddr3_dm_tdqs_out !== 2'b00) begin
               n_fail++; $display("FAIL wr_beat k=%0d got %h exp %h", k, ddr3_data_out, 16'h1000 + 16'((k > 13) ? 7 : k - 6));
            end
         end
         if (k == 6) begin
            n_checks++;
            if (ddr3_data_all_out !== d) begin
               n_fail++; $display("FAIL wr_data_all got %h exp %h", ddr3_data_all_out, d);
            end
         end
         n_checks++;
         if (cmd_ready !== (k == 16)) begin
            n_fail++; $display("FAIL wr_cmd_ready k=%0d got %b exp %b", k, cmd_ready, (k == 16));
         end
         if (k < 16) @(negedge clk);
      end
   endtask

   task automatic test_read;
      logic [127:0] exp_d;
      exp_d = pattern(16'h00A0);
      issue(1'b0, 1'b1, 4'd0, 4'd6, '0, '0);
      for (int k = 1; k <= 15; k++) begin
         ddr3_data_in = (k >= 6 && k <= 13) ? 16'h00A0 + 16'(k - 6) : 16'hDEAD;
         n_checks++;
         if (rd_data_valid !== (k == 14) || ddr3_rw !== 1'b1 || ddr3_odt !== 1'b0) begin
            n_fail++; $display("FAIL rd_pulse k=%0d got valid=%b rw=%b odt=%b exp valid=%b", k, rd_data_valid,
                               ddr3_rw, ddr3_odt, (k == 14));
         end
         if (k >= 14) begin
            n_checks++;
            if (rd_data !== exp_d) begin
               n_fail++; $display("FAIL rd_data k=%0d got %h exp %h", k, rd_data, exp_d);
            end
         end
         if (k == 15) begin
            n_checks++;
            if (cmd_ready !== 1'b1) begin
               n_fail++; $display("FAIL rd_cmd_ready got %b exp 1", cmd_ready);
            end
         end
         if (k < 15) @(negedge clk);
      end
   endtask

   task automatic test_collision;
      logic [127:0] d;
      logic [15:0] m;
      d = pattern(16'h4400);
      m = 16'h1B27;
      issue(1'b1, 1'b1, 4'd1, 4'd1, d, m);
      for (int k = 1; k <= 14; k++) begin
         n_checks++;
         if (ddr3_rw !== !(k <= 10) || rd_data_valid !== 1'b0 || cmd_ready !== (k >= 12)) begin
            n_fail++; $display("FAIL coll_ctrl k=%0d got rw=%b rdv=%b rdy=%b exp rw=%b rdv=0 rdy=%b", k, ddr3_rw,
                               rd_data_valid, cmd_ready, !(k <= 10), (k >= 12));
         end
         if (k >= 2 && k <= 9) begin
            n_checks++;
            if (ddr3_data_out !== d[(k-2)*16 +: 16] || ddr3_dm_tdqs_out !== m[(k-2)*2 +: 2]) begin
               n_fail++; $display("FAIL coll_beat k=%0d got %h/%b exp %h/%b", k, ddr3_data_out, ddr3_dm_tdqs_out,
                                  d[(k-2)*16 +: 16], m[(k-2)*2 +: 2]);
            end
         end
         if (k < 14) @(negedge clk);
      end
   endtask

   task automatic test_zero_latency;
      logic [127:0] d, exp_d;
      d = pattern(16'h2000);
      exp_d = pattern(16'h00B0);
      issue(1'b1, 1'b0, 4'd0, 4'd0, d, 16'h0);
      for (int k = 1; k <= 12; k++) begin
         n_checks++;
         if (ddr3_rw !== !(k <= 10) || cmd_ready !== (k == 12)) begin
            n_fail++; $display("FAIL cwl0_ctrl k=%0d got rw=%b rdy=%b exp rw=%b rdy=%b", k, ddr3_rw, cmd_ready,
                               !(k <= 10), (k == 12));
         end
         if (k >= 2 && k <= 9) begin
            n_checks++;
            if (ddr3_data_out !== 16'h2000 + 16'(k - 2)) begin
               n_fail++; $display("FAIL cwl0_beat k=%0d got %h exp %h", k, ddr3_data_out, 16'h2000 + 16'(k - 2));
            end
         end
         if (k < 12) @(negedge clk);
      end
      issue(1'b0, 1'b1, 4'd0, 4'd0, '0, '0);
      for (int k = 1; k <= 10; k++) begin
         ddr3_data_in = (k <= 8) ? 16'h00B0 + 16'(k - 1) : 16'hDEAD;
         n_checks++;
         if (rd_data_valid !== (k == 9) || cmd_ready !== (k == 10)) begin
            n_fail++; $display("FAIL cl0_ctrl k=%0d got rdv=%b rdy=%b exp rdv=%b rdy=%b", k, rd_data_valid,
                               cmd_ready, (k == 9), (k == 10));
         end
         if (k == 9) begin
            n_checks++;
            if (rd_data !== exp_d) begin
               n_fail++; $display("FAIL cl0_data got %h exp %h", rd_data, exp_d);
            end
         end
         if (k < 10) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_burst;
      logic [127:0] d;
      d = pattern(16'h3300);
      issue(1'b1, 1'b0, 4'd1, 4'd0, d, 16'h0);
      repeat (4) @(negedge clk);
      n_checks++;
      if (ddr3_data_out !== 16'h3303 || ddr3_rw !== 1'b0) begin
         n_fail++; $display("FAIL rst_pre beat3 got %h rw=%b exp 3303 rw=0", ddr3_data_out, ddr3_rw);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ddr3_rw !== 1'b1 || ddr3_odt !== 1'b0 || ddr3_dqs_out !== 2'b00 || ddr3_dqs_n_out !== 2'b11
          || cmd_ready !== 1'b1 || rd_data !== '0 || rd_data_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_async got rw=%b odt=%b dqs=%b dqs_n=%b rdy=%b rdv=%b exp 1 0 00 11 1 0",
                            ddr3_rw, ddr3_odt, ddr3_dqs_out, ddr3_dqs_n_out, cmd_ready, rd_data_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      d = pattern(16'h5500);
      issue(1'b1, 1'b0, 4'd2, 4'd0, d, 16'h0);
      for (int k = 1; k <= 13; k++) begin
         n_checks++;
         if (ddr3_rw !== !(k >= 2 && k <= 11) || cmd_ready !== (k == 13)) begin
            n_fail++; $display("FAIL rst_next_ctrl k=%0d got rw=%b rdy=%b", k, ddr3_rw, cmd_ready);
         end
         if (k >= 3 && k <= 10) begin
            n_checks++;
            if (ddr3_data_out !== 16'h5500 + 16'(k - 3)) begin
               n_fail++; $display("FAIL rst_next_beat k=%0d got %h exp %h", k, ddr3_data_out, 16'h5500 + 16'(k - 3));
            end
         end
         if (k < 13) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      logic [127:0] exp_d;
      logic seen_w;
      int gap;
      bit got_ready;
      seen_w = 1'b0; gap = 0; got_ready = 1'b0;
      exp_d = pattern(16'h00C0);
      issue(1'b1, 1'b0, 4'd1, 4'd0, pattern(16'h3000), 16'h0);
      for (int k = 1; k <= 30; k++) begin
         if (ddr3_rw === 1'b0) begin
            seen_w = 1'b1; gap = 0;
         end else if (seen_w && ddr3_odt === 1'b0) gap++;
         if (cmd_ready === 1'b1) begin
            got_ready = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (!got_ready || !seen_w || gap < 1) begin
         n_fail++; $display("FAIL b2b_gap ready=%b seen_write=%b idle_cycles=%0d exp ready, write, >=1", got_ready,
                            seen_w, gap);
      end
      if (got_ready) begin
         issue(1'b0, 1'b1, 4'd0, 4'd2, '0, '0);
         for (int k = 1; k <= 10; k++) begin
            ddr3_data_in = (k >= 2 && k <= 9) ? 16'h00C0 + 16'(k - 2) : 16'hDEAD;
            n_checks++;
            if (rd_data_valid !== (k == 10) || ddr3_rw !== 1'b1) begin
               n_fail++; $display("FAIL b2b_rd k=%0d got rdv=%b rw=%b exp rdv=%b rw=1", k, rd_data_valid, ddr3_rw,
                                  (k == 10));
            end
            if (k == 10) begin
               n_checks++;
               if (rd_data !== exp_d) begin
                  n_fail++; $display("FAIL b2b_rd_data got %h exp %h", rd_data, exp_d);
               end
            end
            if (k < 10) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      @(negedge clk);
      test_collision;
      test_zero_latency;
      test_reset_mid_burst;
      test_back_to_back;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
